// File: rtl/uart_rx_pkg.sv
// Baud constants, state/baud enums and divider helpers shared by the UART blocks.
// Divider counts are rounded to the nearest clock; CNT_RST is half a bit period.
package uart_rx_pkg;

   localparam int unsigned UART_CLK_HZ   = 50_000_000;
   localparam int unsigned UART_CNT_SIZE = 13;

   typedef enum logic [2:0] {
      BAUD_9600   = 3'd0,
      BAUD_19200  = 3'd1,
      BAUD_38400  = 3'd2,
      BAUD_57600  = 3'd3,
      BAUD_115200 = 3'd4
   } uart_baud_t;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

   function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned rate);
      return (clk_hz + rate / 2) / rate;
   endfunction

   localparam int unsigned UART_9600_CNT       = uart_div(UART_CLK_HZ, 9600);
   localparam int unsigned UART_19200_CNT      = uart_div(UART_CLK_HZ, 19200);
   localparam int unsigned UART_38400_CNT      = uart_div(UART_CLK_HZ, 38400);
   localparam int unsigned UART_57600_CNT      = uart_div(UART_CLK_HZ, 57600);
   localparam int unsigned UART_115200_CNT     = uart_div(UART_CLK_HZ, 115200);
   localparam int unsigned UART_9600_CNT_RST   = UART_9600_CNT / 2;
   localparam int unsigned UART_19200_CNT_RST  = UART_19200_CNT / 2;
   localparam int unsigned UART_38400_CNT_RST  = UART_38400_CNT / 2;
   localparam int unsigned UART_57600_CNT_RST  = UART_57600_CNT / 2;
   localparam int unsigned UART_115200_CNT_RST = UART_115200_CNT / 2;

   // Each branch divides constants only, so a parameterised clk_hz still folds to a mux.
   function automatic logic [UART_CNT_SIZE-1:0] uart_baud_cnt(input uart_baud_t b,
                                                              input int unsigned clk_hz = UART_CLK_HZ);
      int unsigned c;
      case (b)
         BAUD_9600:  c = uart_div(clk_hz, 9600);
         BAUD_19200: c = uart_div(clk_hz, 19200);
         BAUD_38400: c = uart_div(clk_hz, 38400);
         BAUD_57600: c = uart_div(clk_hz, 57600);
         default:    c = uart_div(clk_hz, 115200);
      endcase
      return UART_CNT_SIZE'(c);
   endfunction

   function automatic logic [UART_CNT_SIZE-1:0] uart_baud_cnt_rst(input uart_baud_t b,
                                                                  input int unsigned clk_hz = UART_CLK_HZ);
      return uart_baud_cnt(b, clk_hz) >> 1;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for an asynchronous single-bit input; latency STAGES cycles.
// Reset value is a parameter so idle-high lines do not produce a false edge.
module sync_ff #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_sync <= {STAGES{RST_VAL}};
      else       r_sync <= {r_sync[STAGES-2:0], i_d};
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, one mid-bit sample per bit; byte out ~SYNC+2+CNT_RST+9*CNT cycles after start edge.
// valid/ready output; a byte completing while the previous one is unconsumed is dropped and sets overrun_o.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int          SYNC_STAGES = 2,
   // Clock rate used for divider constants; counts must fit in UART_CNT_SIZE bits.
   parameter int unsigned CLK_FREQ    = UART_CLK_HZ
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   input  logic [2:0] baud_sel_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       frame_err_o,
   output logic       overrun_o,
   input  logic       clr_ovr_i
);

   localparam int CW = UART_CNT_SIZE;
   localparam logic [CW-1:0] ONE = CW'(1);
   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_START = START;
   localparam logic [1:0] ST_DATA  = DATA;
   localparam logic [1:0] ST_STOP  = STOP;

   logic                w_rx_s;
   logic                r_rx_q;
   logic [SYNC_STAGES:0] r_settle;
   logic                r_armed;
   logic [1:0]          r_state;
   logic [CW-1:0]       r_cnt;
   logic [CW-1:0]       r_bit_cnt;
   logic [2:0]          r_idx;
   logic [7:0]          r_shift;
   logic [CW-1:0]       w_sel_cnt;
   logic [CW-1:0]       w_sel_rst;
   logic                w_tick;
   logic                w_start;
   logic                w_commit;
   logic                w_ferr;

   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
      .i_clk (clk),
      .i_rst (rst),
      .i_d   (rx_i),
      .o_q   (w_rx_s)
   );

   assign w_sel_cnt = uart_baud_cnt(uart_baud_t'(baud_sel_i), CLK_FREQ);
   assign w_sel_rst = uart_baud_cnt_rst(uart_baud_t'(baud_sel_i), CLK_FREQ);
   assign w_tick    = (r_cnt == '0);
   // Only a line seen high after the synchronizer has flushed may start a frame.
   assign w_start   = r_armed && r_rx_q && !w_rx_s;
   assign w_commit  = (r_state == ST_STOP) && w_tick && w_rx_s;
   assign w_ferr    = (r_state == ST_STOP) && w_tick && !w_rx_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_q    <= 1'b1;
         r_settle  <= '0;
         r_armed   <= 1'b0;
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_bit_cnt <= '0;
         r_idx     <= '0;
         r_shift   <= '0;
      end else begin
         r_rx_q   <= w_rx_s;
         r_settle <= {r_settle[SYNC_STAGES-1:0], 1'b1};
         if (r_settle[SYNC_STAGES] && w_rx_s) r_armed <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_bit_cnt <= w_sel_cnt;
                  r_cnt     <= w_sel_rst - ONE;
                  r_state   <= ST_START;
               end
            end
            ST_START: begin
               if (!w_tick) begin
                  r_cnt <= r_cnt - ONE;
               end else if (!w_rx_s) begin
                  r_cnt   <= r_bit_cnt - ONE;
                  r_idx   <= '0;
                  r_state <= ST_DATA;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_DATA: begin
               if (!w_tick) begin
                  r_cnt <= r_cnt - ONE;
               end else begin
                  r_shift <= {w_rx_s, r_shift[7:1]};
                  r_cnt   <= r_bit_cnt - ONE;
                  r_idx   <= r_idx + 3'd1;
                  if (r_idx == 3'd7) r_state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (!w_tick) begin
                  r_cnt <= r_cnt - ONE;
               end else begin
                  r_state <= ST_IDLE;
                  if (!w_rx_s) r_armed <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_o      <= '0;
         valid_o     <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         frame_err_o <= w_ferr;
         if (w_commit && (!valid_o || ready_i)) begin
            data_o  <= r_shift;
            valid_o <= 1'b1;
         end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
         end
         // Setting has priority over clearing in the same cycle.
         if (w_commit && valid_o && !ready_i) overrun_o <= 1'b1;
         else if (clr_ovr_i)                  overrun_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at a reduced 12.5 MHz clock: table-driven frames plus hand-written corner sequences.
module tb_uart_rx;

   localparam int CLK_HZ = 12_500_000;
   localparam int SYNC   = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_i;
   logic [2:0] baud_sel_i;
   logic [7:0] data_o;
   logic       valid_o;
   logic       ready_i;
   logic       frame_err_o;
   logic       overrun_o;
   logic       clr_ovr_i;

   uart_rx #(.SYNC_STAGES(SYNC), .CLK_FREQ(CLK_HZ)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_i        (rx_i),
      .baud_sel_i  (baud_sel_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o),
      .clr_ovr_i   (clr_ovr_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] sel;
      logic [7:0] dat;
      logic       stop;
      logic       exp_vld;
      logic       exp_ferr;
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [7:0] sb[$];
   int         rise_cyc = 0;
   int         vld_rises = 0;
   int         vld_cycles = 0;
   int         ferr_cnt = 0;
   logic       prev_vld = 1'b0;
   logic       prev_hs = 1'b0;
   logic [7:0] prev_data = 8'h00;

   // 12.5 MHz / baud, rounded: 1302, 651, 326, 217, 109.
   function automatic int bit_cnt(input logic [2:0] s);
      case (s)
         3'd0:    return 1302;
         3'd1:    return 651;
         3'd2:    return 326;
         3'd3:    return 217;
         default: return 109;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic v, input int n);
      rx_i = v;
      tick(n);
   endtask

   task automatic send_frame(input int n, input logic [7:0] b, input logic stop);
      drive_bit(1'b0, n);
      for (int i = 0; i < 8; i++) drive_bit(b[i], n);
      drive_bit(stop, n);
   endtask

   task automatic idle(input int n);
      rx_i = 1'b1;
      tick(n);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid_o && !prev_vld) begin
         rise_cyc = cyc;
         vld_rises++;
      end
      if (valid_o) vld_cycles++;
      if (frame_err_o) ferr_cnt++;
      if (prev_vld && !prev_hs && valid_o) chk("data_stable", data_o, prev_data);
      if (valid_o && ready_i) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual=%02h required=none", data_o);
         end else begin
            chk("sb_data", data_o, sb.pop_front());
         end
      end
      prev_vld  = valid_o;
      prev_hs   = valid_o && ready_i;
      prev_data = data_o;
   end

   initial begin
      repeat (150000) @(posedge clk);
      $display("FAIL watchdog cycles=%0d limit=150000", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      vec_t       vecs[7];
      int         n, br, bc, bf, t0, lat;
      logic [7:0] b;

      vecs[0] = '{3'd4, 8'h01, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{3'd4, 8'h80, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{3'd7, 8'hDB, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{3'd5, 8'h00, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{3'd4, 8'h6B, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{3'd3, 8'hF0, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{3'd3, 8'hFF, 1'b0, 1'b0, 1'b1};

      rst = 1'b1; rx_i = 1'b0; ready_i = 1'b1; clr_ovr_i = 1'b0; baud_sel_i = 3'd4;
      tick(4);
      chk("rst_data", data_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_ferr", frame_err_o, 0);
      chk("rst_ovr", overrun_o, 0);
      rst = 1'b0;

      // Line held low out of reset must not look like a start bit.
      tick(1200);
      chk("low_after_rst_vld", vld_rises, 0);
      chk("low_after_rst_ferr", ferr_cnt, 0);
      idle(200);

      // 0xA5 at 115200: single-cycle valid and start-to-valid latency.
      n = bit_cnt(3'd4);
      br = vld_rises; bc = vld_cycles;
      sb.push_back(8'hA5);
      t0 = cyc;
      send_frame(n, 8'hA5, 1'b1);
      idle(n);
      lat = SYNC + 2 + n / 2 + 9 * n;
      chk("a5_rises", vld_rises - br, 1);
      chk("a5_vld_cycles", vld_cycles - bc, 1);
      chk_range("a5_latency", rise_cyc - t0, lat - 1, lat + 1);

      for (int i = 0; i < 7; i++) begin
         baud_sel_i = vecs[i].sel;
         n  = bit_cnt(vecs[i].sel);
         br = vld_rises; bf = ferr_cnt;
         if (vecs[i].exp_vld) sb.push_back(vecs[i].dat);
         send_frame(n, vecs[i].dat, vecs[i].stop);
         idle(n);
         chk($sformatf("vec%0d_vld", i), vld_rises - br, int'(vecs[i].exp_vld));
         chk($sformatf("vec%0d_ferr", i), ferr_cnt - bf, int'(vecs[i].exp_ferr));
      end
      chk("vec_sb_empty", sb.size(), 0);

      // Overrun at 9600: second byte dropped, first stays.
      baud_sel_i = 3'd0; ready_i = 1'b0; n = bit_cnt(3'd0);
      br = vld_rises;
      sb.push_back(8'h00);
      send_frame(n, 8'h00, 1'b1);
      send_frame(n, 8'hFF, 1'b1);
      tick(4);
      chk("ovr_valid", valid_o, 1);
      chk("ovr_data", data_o, 8'h00);
      chk("ovr_flag", overrun_o, 1);
      chk("ovr_rises", vld_rises - br, 1);
      ready_i = 1'b1;
      tick(2);
      chk("ovr_hs_valid", valid_o, 0);
      chk("ovr_sticky", overrun_o, 1);
      clr_ovr_i = 1'b1;
      tick(1);
      clr_ovr_i = 1'b0;
      chk("ovr_cleared", overrun_o, 0);

      // Framing error at 38400, then line low for two frames, then recovery.
      baud_sel_i = 3'd2; n = bit_cnt(3'd2);
      br = vld_rises; bf = ferr_cnt;
      send_frame(n, 8'h3C, 1'b0);
      tick(20 * n);
      chk("ferr_pulses", ferr_cnt - bf, 1);
      chk("ferr_no_vld", vld_rises - br, 0);
      idle(n);
      sb.push_back(8'h11);
      send_frame(n, 8'h11, 1'b1);
      idle(n);
      chk("ferr_recover_vld", vld_rises - br, 1);
      chk("ferr_recover_ferr", ferr_cnt - bf, 1);

      // 100-cycle glitch at 57600 (half bit is 108 cycles).
      baud_sel_i = 3'd3; n = bit_cnt(3'd3);
      br = vld_rises; bf = ferr_cnt;
      rx_i = 1'b0;
      tick(100);
      rx_i = 1'b1;
      tick(300);
      chk("glitch_vld", vld_rises - br, 0);
      chk("glitch_ferr", ferr_cnt - bf, 0);
      sb.push_back(8'h96);
      send_frame(n, 8'h96, 1'b1);
      idle(n);
      chk("glitch_next_vld", vld_rises - br, 1);

      // Overrun with clear held high across the commit: set wins.
      baud_sel_i = 3'd4; n = bit_cnt(3'd4); ready_i = 1'b0;
      send_frame(n, 8'h33, 1'b1);
      b = 8'h44;
      clr_ovr_i = 1'b1;
      drive_bit(1'b0, n);
      for (int i = 0; i < 8; i++) drive_bit(b[i], n);
      rx_i = 1'b1;
      for (int k = 0; k < n && !overrun_o; k++) tick(1);
      clr_ovr_i = 1'b0;
      tick(n);
      chk("setwins_ovr", overrun_o, 1);
      chk("setwins_valid", valid_o, 1);
      chk("setwins_data", data_o, 8'h33);

      // Reset in the middle of data bit 4 of 0x55.
      b = 8'h55;
      drive_bit(1'b0, n);
      for (int i = 0; i < 4; i++) drive_bit(b[i], n);
      rx_i = b[4];
      tick(50);
      rst = 1'b1;
      tick(1);
      chk("midrst_data", data_o, 0);
      chk("midrst_valid", valid_o, 0);
      chk("midrst_ferr", frame_err_o, 0);
      chk("midrst_ovr", overrun_o, 0);
      rst = 1'b0;
      idle(2 * n);
      ready_i = 1'b1;
      br = vld_rises;
      sb.push_back(8'h81);
      send_frame(n, 8'h81, 1'b1);
      idle(n);
      chk("midrst_next_vld", vld_rises - br, 1);

      // Baud switched 115200 -> 9600 mid-frame; then 9600 frame; then sel 6 as 115200.
      br = vld_rises;
      b = 8'h7E;
      sb.push_back(b);
      drive_bit(1'b0, n);
      for (int i = 0; i < 8; i++) begin
         if (i == 4) baud_sel_i = 3'd0;
         drive_bit(b[i], n);
      end
      drive_bit(1'b1, n);
      idle(n);
      chk("bsw_first_vld", vld_rises - br, 1);
      sb.push_back(8'hC3);
      send_frame(bit_cnt(3'd0), 8'hC3, 1'b1);
      idle(200);
      baud_sel_i = 3'd6;
      sb.push_back(8'h5A);
      send_frame(bit_cnt(3'd6), 8'h5A, 1'b1);
      idle(n);
      chk("bsw_all_vld", vld_rises - br, 3);

      chk("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver.
- Oversample-free: one mid-bit sample per bit, timed by a clock-divider counter loaded from the package baud constants (UART_*_CNT, UART_*_CNT_RST, UART_CNT_SIZE).
- Converts the asynchronous rx pin into bytes on a valid/ready interface.
- Consumed by the UART peripheral's register/FIFO logic on the CPU bus.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the rx input synchronizer (minimum 2)

Ports:
clk  input  1  system clock, FREQUENCY Hz
rst  input  1  synchronous active-high reset
rx_i  input  1  asynchronous serial line, idle high
baud_sel_i  input  3  0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5..7=115200
data_o  output  8  received byte, LSB received first
valid_o  output  1  data_o holds an unconsumed byte
ready_i  input  1  consumer accepts data_o when valid_o && ready_i
frame_err_o  output  1  one-cycle pulse: stop bit sampled low
overrun_o  output  1  sticky: a byte was dropped because valid_o was still high
clr_ovr_i  input  1  clears overrun_o

Behaviour:
- Reset (sync, active-high, any state, mid-frame included):
  - state=IDLE, counter=0, bit index=0, shift register=0.
  - Synchronizer flops and edge-detect register=1.
  - data_o=0, valid_o=0, frame_err_o=0, overrun_o=0.
- rx_i passes through SYNC_STAGES flops to give rx_s; rx_q is rx_s delayed by 1. All decisions use rx_s only.
- Baud select:
  - baud_sel_i is decoded to (CNT, CNT_RST) and latched only on start detection.
  - Changes mid-frame take effect next frame.
- Counter:
  - Width UART_CNT_SIZE, down-counting.
  - A bit period is exactly CNT cycles: reload with CNT-1, event when counter==0.
- State machine:
  - IDLE: on rx_q==1 && rx_s==0 (falling edge), latch baud, load CNT_RST-1, go to START. A line held low after reset or after a framing error does not trigger a start.
  - START, counter==0:
    - If rx_s==0: load CNT-1, bit index=0, go to DATA.
    - Otherwise (glitch): go to IDLE with no outputs.
  - DATA, counter==0:
    - Shift rx_s in at MSB (shift right), so bit 0 ends at LSB.
    - Reload CNT-1 and increment the index.
    - After the 8th bit, go to STOP.
  - STOP, counter==0:
    - If rx_s==1: commit the byte.
    - Else: pulse frame_err_o for 1 cycle and discard the byte.
    - Go to IDLE in either case.
- Commit (registered, outputs change the cycle after the stop sample):
  - valid_o==0, or valid_o && ready_i in the same cycle: data_o<=byte, valid_o<=1.
  - valid_o && !ready_i: keep the old data_o, drop the new byte, set overrun_o.
- Handshake: valid_o && ready_i with no commit pending clears valid_o next cycle. data_o stays stable while valid_o is high.
- overrun_o:
  - Cleared by clr_ovr_i.
  - A set and a clear in the same cycle: set wins.
- Latency: valid_o rises SYNC_STAGES + 2 + CNT_RST + 9*CNT cycles (±1) after the rx_i falling edge.

Decomposition:
- Add to the constants package:
  - typedef enum logic [2:0] uart_baud_t (BAUD_9600..BAUD_115200).
  - typedef enum uart_rx_state_t {IDLE, START, DATA, STOP}.
  - A function uart_baud_cnt(uart_baud_t) returning CNT.
  - A function uart_baud_cnt_rst(uart_baud_t) returning CNT_RST.
- One sub-module: sync_ff (parameterised-depth synchronizer). It is reused later by uart_tx/GPIO.

Test Plan:
- 115200, send 0xA5 with ready_i=1 -> data_o=0xA5, valid_o high 1 cycle. Rise time = edge + SYNC_STAGES + 2 + 217 + 9*434 cycles, ±1.
- 9600, send 0x00 then 0xFF back-to-back with ready_i=0, then ready_i=1 -> data_o stays 0x00, overrun_o=1. After the handshake valid_o=0; a clr_ovr_i pulse clears overrun_o.
- Stop bit driven low at 38400 sending 0x3C -> frame_err_o pulses once, valid_o stays 0. Line held low 2 frames: no new start; after the line goes high, 0x11 is received correctly.
- Low glitch of 100 cycles at 57600 (shorter than CNT_RST=434) -> no valid_o, no frame_err_o, FSM back in IDLE.
- Assert rst during DATA bit 4 of 0x55 -> all outputs 0 the next cycle. A following frame 0x81 is received intact.
- baud_sel_i changed from 115200 to 9600 mid-frame of 0x7E -> 0x7E is received at 115200. The next frame is received at 9600; baud_sel_i=6 behaves as 115200.
